fpnew_pipe_elastic: RTL and testbench
=====================================

Name: fpnew_pipe_elastic

Overview:
- Parametrised elastic pipeline for FPU operation slices; successor to the plain in-pipe register chain.
- Carries an opaque payload plus tag through NumStages register stages, with bubble collapsing.
- Optional per-stage skid buffering (ReadyCut) cuts the combinational ready path.
- Selective tag-masked kill for speculative squash, full flush, and an occupancy count for the issue logic.

Parameters:
DataWidth, 64, payload width in bits (operands, op, formats packed by instantiator)
TagWidth, 8, tag width in bits; compared for selective kill
NumStages, 2, register stages; 0 = combinational pass-through
ReadyCut, 0, 0 = ready chained combinationally with bubble collapse; 1 = every stage is a 2-entry skid buffer, in_ready_o purely registered
OccWidth, $clog2(2*NumStages+1) (min 1), occupancy count width (derived, do not override)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
data_i  in  DataWidth  input payload
tag_i  in  TagWidth  input tag
in_valid_i  in  1  input valid
in_ready_o  out  1  input ready
data_o  out  DataWidth  output payload
tag_o  out  TagWidth  output tag
out_valid_o  out  1  output valid
out_ready_i  in  1  output ready
flush_i  in  1  invalidate all entries
kill_i  in  1  invalidate entries matching kill_tag_i under kill_mask_i
kill_tag_i  in  TagWidth  kill compare value
kill_mask_i  in  TagWidth  kill compare mask (1 = bit compared)
occupancy_o  out  OccWidth  number of valid stored entries
busy_o  out  1  in_valid_i OR any stored entry valid

Behaviour:
- Reset (rst_i=1 at edge): all valid bits 0; data/tag regs to 0. After reset: out_valid_o=0, data_o=0, tag_o=0, occupancy_o=0, in_ready_o=1 (NumStages>0), busy_o=in_valid_i. Reset mid-transfer drops everything; reset has priority over flush, kill and handshakes.
- Handshake: transfer when valid&ready at an edge. Valid never depends combinationally on ready. Payload/tag stable while out_valid_o=1 and out_ready_i=0 (unless killed/flushed, which takes effect at the next edge).
- Latency: NumStages cycles from input accept to out_valid_o, unstalled, both ReadyCut modes. Throughput 1/cycle.
- ReadyCut=0: stage_ready[i] = stage_ready[i+1] | ~valid[i]; last stage_ready = out_ready_i. Register enable = stage_ready & incoming valid (clock-gatable); valid reg enabled by stage_ready.
- ReadyCut=1: stage holds main + skid entry. Ready to upstream = ~skid_valid (registered). Upstream push while downstream stalled fills skid; skid drains to main first (FIFO order). No bubble is ever inserted between back-to-back items.
- Occupancy: popcount of all main+skid valids; max NumStages (ReadyCut=0) or 2*NumStages.
- flush_i: all valids 0 at next edge; an input accepted in the same cycle is dropped; out_valid_o is not masked combinationally, so an output handshake in the flush cycle counts as delivered.
- kill_i: at next edge, clear every stored entry with (tag & kill_mask_i) == (kill_tag_i & kill_mask_i); an entry accepted that cycle is checked with tag_i and dropped if matching. Non-matching entries keep position and order. Output handshake in kill cycle counts as delivered.
- flush_i and kill_i together: flush wins.
- NumStages=0: data_o=data_i, tag_o=tag_i, out_valid_o=in_valid_i, in_ready_o=out_ready_i; flush/kill ignored; occupancy_o=0.

Decomposition:
- fpnew_pkg: add function kill_match(tag, kill_tag, mask) shared with other kill-capable units. No new typedefs; payload stays a flat vector.
- Sub-module fpnew_pipe_elastic_stage: one stage (main + optional skid) with valid/ready, kill, flush. The top is a generate chain of these plus popcount.

Test Plan:
- NumStages=3, ReadyCut=0, out_ready_i=1, push tags 1..5 back-to-back -> out_valid_o first at cycle 3, tags 1..5 on consecutive cycles, occupancy_o peaks at 3.
- NumStages=3, ReadyCut=0, out_ready_i=0, push tag 7 only -> in_ready_o stays 1 for 2 further pushes (bubbles collapse), goes 0 with occupancy_o=3.
- ReadyCut=1, NumStages=2, random out_ready_i, 200 items -> in-order, lossless, no duplicates; in_ready_o never changes combinationally with out_ready_i; occupancy_o ≤ 4.
- Pipeline holds tags 0x12,0x22,0x13; kill_i with tag 0x02, mask 0x0F -> next cycle 0x12,0x22 removed, 0x13 remains, occupancy_o=1.
- flush_i together with kill_i and in_valid_i=1 (tag 0x40) -> next cycle occupancy_o=0, out_valid_o=0, 0x40 never appears.
- rst_i asserted with 2 valid entries and out_ready_i=0 -> next cycle out_valid_o=0, data_o=0, occupancy_o=0, in_ready_o=1.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPU helpers used by kill-capable units.
package fpnew_pkg;

  // Widest tag any kill-capable unit may use; callers zero-extend into this width.
  localparam int unsigned MaxTagWidth = 32;

  // True when tag equals kill_tag on every bit selected by mask.
  function automatic logic kill_match(input logic [MaxTagWidth-1:0] tag,
                                      input logic [MaxTagWidth-1:0] kill_tag,
                                      input logic [MaxTagWidth-1:0] mask);
    return ((tag ^ kill_tag) & mask) == '0;
  endfunction

endpackage

// File: rtl/fpnew_pipe_elastic_stage.sv
// One elastic pipeline stage: a main register plus, when ReadyCut is set, a skid entry
// so that the upstream ready is purely registered.
module fpnew_pipe_elastic_stage
  import fpnew_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TagWidth  = 8,
  parameter int unsigned ReadyCut  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 kill_i,
  input  logic [TagWidth-1:0]  kill_tag_i,
  input  logic [TagWidth-1:0]  kill_mask_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [TagWidth-1:0]  tag_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [TagWidth-1:0]  tag_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [1:0]           occ_o
);

  logic                 valid_q, valid_d, skid_valid_q, skid_valid_d;
  logic [DataWidth-1:0] data_q, data_d, skid_data_q, skid_data_d;
  logic [TagWidth-1:0]  tag_q, tag_d, skid_tag_q, skid_tag_d;
  logic                 kill_main, kill_skid, kill_in;
  logic                 push, main_keep, skid_keep, in_keep;

  assign kill_main = flush_i | (kill_i & kill_match(MaxTagWidth'(tag_q), MaxTagWidth'(kill_tag_i),
                                                    MaxTagWidth'(kill_mask_i)));
  assign kill_skid = flush_i | (kill_i & kill_match(MaxTagWidth'(skid_tag_q),
                                                    MaxTagWidth'(kill_tag_i),
                                                    MaxTagWidth'(kill_mask_i)));
  assign kill_in   = flush_i | (kill_i & kill_match(MaxTagWidth'(tag_i), MaxTagWidth'(kill_tag_i),
                                                    MaxTagWidth'(kill_mask_i)));

  // Without a skid entry a bubble in main lets the stage accept even while stalled.
  assign in_ready_o = (ReadyCut == 0) ? (out_ready_i | ~valid_q) : ~skid_valid_q;
  assign push       = in_valid_i & in_ready_o;

  // Entries that survive this edge: main not popped, and nothing killed or flushed.
  assign main_keep = valid_q & ~out_ready_i & ~kill_main;
  assign skid_keep = skid_valid_q & ~kill_skid;
  assign in_keep   = push & ~kill_in;

  // Next state: compact surviving entries in arrival order (main, skid, input).
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    tag_d        = tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    if (ReadyCut == 0) begin
      skid_valid_d = 1'b0;
      if (in_ready_o) begin
        valid_d = in_keep;
        if (in_valid_i) begin
          data_d = data_i;
          tag_d  = tag_i;
        end
      end else begin
        valid_d = main_keep;
      end
    end else if (main_keep) begin
      // A push implies an empty skid, so at most one of skid/input survives here.
      if (!skid_keep && in_keep) begin
        skid_valid_d = 1'b1;
        skid_data_d  = data_i;
        skid_tag_d   = tag_i;
      end else begin
        skid_valid_d = skid_keep;
      end
    end else if (skid_keep) begin
      valid_d      = 1'b1;
      data_d       = skid_data_q;
      tag_d        = skid_tag_q;
      skid_valid_d = in_keep;
      if (in_keep) begin
        skid_data_d = data_i;
        skid_tag_d  = tag_i;
      end
    end else begin
      valid_d      = in_keep;
      skid_valid_d = 1'b0;
      if (in_keep) begin
        data_d = data_i;
        tag_d  = tag_i;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      tag_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid_o = valid_q;
  assign data_o      = data_q;
  assign tag_o       = tag_q;
  assign occ_o       = {1'b0, valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/fpnew_pipe_elastic.sv
// Elastic pipeline for FPU slices: a chain of stages carrying payload and tag, with
// selective kill, flush and an occupancy count for the issue logic.
module fpnew_pipe_elastic
  import fpnew_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TagWidth  = 8,
  parameter int unsigned NumStages = 2,
  parameter int unsigned ReadyCut  = 0,
  parameter int unsigned OccWidth  = (NumStages == 0) ? 1 : $clog2(2 * NumStages + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [TagWidth-1:0]  tag_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [TagWidth-1:0]  tag_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 flush_i,
  input  logic                 kill_i,
  input  logic [TagWidth-1:0]  kill_tag_i,
  input  logic [TagWidth-1:0]  kill_mask_i,
  output logic [OccWidth-1:0]  occupancy_o,
  output logic                 busy_o
);

  if (NumStages == 0) begin : g_bypass
    // No storage: control inputs have nothing to act on.
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_i, flush_i, kill_i, kill_tag_i, kill_mask_i};
    assign data_o      = data_i;
    assign tag_o       = tag_i;
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign occupancy_o = '0;
    assign busy_o      = in_valid_i;
  end else begin : g_pipe
    // Per-stage boundary signals live in their own scope so the ready chain is acyclic.
    for (genvar i = 0; i < NumStages; i++) begin : g_stage
      logic                 in_v, in_r, out_v, out_r;
      logic [DataWidth-1:0] in_d, out_d;
      logic [TagWidth-1:0]  in_t, out_t;
      logic [1:0]           occ;
      logic [OccWidth-1:0]  occ_acc;

      if (i == 0) begin : g_head
        assign in_v       = in_valid_i;
        assign in_d       = data_i;
        assign in_t       = tag_i;
        assign in_ready_o = in_r;
        assign occ_acc    = OccWidth'(occ);
      end else begin : g_link
        assign in_v    = g_stage[i-1].out_v;
        assign in_d    = g_stage[i-1].out_d;
        assign in_t    = g_stage[i-1].out_t;
        assign occ_acc = g_stage[i-1].occ_acc + OccWidth'(occ);
      end

      if (i == NumStages - 1) begin : g_tail
        assign out_r = out_ready_i;
      end else begin : g_mid
        assign out_r = g_stage[i+1].in_r;
      end

      fpnew_pipe_elastic_stage #(
        .DataWidth (DataWidth),
        .TagWidth  (TagWidth),
        .ReadyCut  (ReadyCut)
      ) u_stage (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .kill_i      (kill_i),
        .kill_tag_i  (kill_tag_i),
        .kill_mask_i (kill_mask_i),
        .data_i      (in_d),
        .tag_i       (in_t),
        .in_valid_i  (in_v),
        .in_ready_o  (in_r),
        .data_o      (out_d),
        .tag_o       (out_t),
        .out_valid_o (out_v),
        .out_ready_i (out_r),
        .occ_o       (occ)
      );
    end

    assign data_o      = g_stage[NumStages-1].out_d;
    assign tag_o       = g_stage[NumStages-1].out_t;
    assign out_valid_o = g_stage[NumStages-1].out_v;
    assign occupancy_o = g_stage[NumStages-1].occ_acc;
    assign busy_o      = in_valid_i | (occupancy_o != '0);
  end

endmodule

// File: tb/tb_fpnew_pipe_elastic.sv
// Scoreboard bench: DUT A (3 stages, combinational ready) and DUT B (2 stages, skid).
module tb_fpnew_pipe_elastic;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // DUT A signals
  logic [DW-1:0] a_data_i = '0, a_data_o;
  logic [TW-1:0] a_tag_i = '0, a_tag_o, a_kill_tag = '0, a_kill_mask = '0;
  logic a_in_valid = 1'b0, a_out_ready = 1'b0, a_flush = 1'b0, a_kill = 1'b0;
  logic a_in_ready, a_out_valid, a_busy;
  logic [2:0] a_occ;

  // DUT B signals
  logic [DW-1:0] b_data_i = '0, b_data_o;
  logic [TW-1:0] b_tag_i = '0, b_tag_o;
  logic b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic b_in_ready, b_out_valid, b_busy;
  logic [2:0] b_occ;

  fpnew_pipe_elastic #(
    .DataWidth (DW),
    .TagWidth  (TW),
    .NumStages (3),
    .ReadyCut  (0)
  ) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (a_data_i),
    .tag_i       (a_tag_i),
    .in_valid_i  (a_in_valid),
    .in_ready_o  (a_in_ready),
    .data_o      (a_data_o),
    .tag_o       (a_tag_o),
    .out_valid_o (a_out_valid),
    .out_ready_i (a_out_ready),
    .flush_i     (a_flush),
    .kill_i      (a_kill),
    .kill_tag_i  (a_kill_tag),
    .kill_mask_i (a_kill_mask),
    .occupancy_o (a_occ),
    .busy_o      (a_busy)
  );

  fpnew_pipe_elastic #(
    .DataWidth (DW),
    .TagWidth  (TW),
    .NumStages (2),
    .ReadyCut  (1)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (b_data_i),
    .tag_i       (b_tag_i),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .data_o      (b_data_o),
    .tag_o       (b_tag_o),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .flush_i     (1'b0),
    .kill_i      (1'b0),
    .kill_tag_i  (8'h00),
    .kill_mask_i (8'h00),
    .occupancy_o (b_occ),
    .busy_o      (b_busy)
  );

  function automatic logic [DW-1:0] data_of(input logic [TW-1:0] t);
    return {t ^ 8'h5A, ~t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitors: pop the expected entry on every output handshake.
  int a_seen = 0, b_seen = 0, a_occ_max = 0, b_occ_max = 0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && a_out_valid && a_out_ready) begin
      a_seen++;
      if (qa.size() == 0) chk("a_spurious_out", {24'h0, a_tag_o}, 32'hFFFF_FFFF);
      else begin
        e = qa.pop_front();
        chk("a_tag", a_tag_o, e.tag);
        chk("a_data", a_data_o, e.data);
        if (e.cyc >= 0) chk("a_latency", cyc, e.cyc);
      end
    end
    if (int'(a_occ) > a_occ_max) a_occ_max = int'(a_occ);
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && b_out_valid && b_out_ready) begin
      b_seen++;
      if (qb.size() == 0) chk("b_spurious_out", {24'h0, b_tag_o}, 32'hFFFF_FFFF);
      else begin
        e = qb.pop_front();
        chk("b_tag", b_tag_o, e.tag);
        chk("b_data", b_data_o, e.data);
        if (e.cyc >= 0) chk("b_latency", cyc, e.cyc);
      end
    end
    if (int'(b_occ) > b_occ_max) b_occ_max = int'(b_occ);
  end

  // Offer one item to A until accepted; queue its expectation on the accepting edge.
  task automatic push_a(input logic [TW-1:0] t, input bit timed);
    exp_t e;
    logic r;
    a_in_valid = 1'b1;
    a_tag_i    = t;
    a_data_i   = data_of(t);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      r = a_in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        e.tag = t; e.data = data_of(t); e.cyc = timed ? cyc + 2 : -1;
        qa.push_back(e);
        return;
      end
    end
    fail_now("a_push_timeout");
  endtask

  task automatic push_b(input logic [TW-1:0] t, input bit timed);
    exp_t e;
    logic r;
    b_in_valid = 1'b1;
    b_tag_i    = t;
    b_data_i   = data_of(t);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      r = b_in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        e.tag = t; e.data = data_of(t); e.cyc = timed ? cyc + 1 : -1;
        qb.push_back(e);
        return;
      end
    end
    fail_now("b_push_timeout");
  endtask

  task automatic drain_a();
    for (int i = 0; i < 200 && qa.size() != 0; i++) @(posedge clk);
    #1;
    chk("a_drain_left", qa.size(), 0);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 2000 && qb.size() != 0; i++) @(posedge clk);
    #1;
    chk("b_drain_left", qb.size(), 0);
  endtask

  // Random out_ready for B, plus a probe that toggles it mid-cycle and watches in_ready.
  bit b_rand = 1'b0;
  int b_comb_err = 0;
  initial begin
    logic r1, r2;
    wait (b_rand);
    while (b_rand) begin
      @(posedge clk);
      #1;
      b_out_ready = 1'($urandom_range(0, 1));
      #2;
      r1 = b_in_ready;
      b_out_ready = ~b_out_ready;
      #1;
      r2 = b_in_ready;
      b_out_ready = ~b_out_ready;
      if (r1 !== r2) b_comb_err++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("a_rst_out_valid", a_out_valid, 0);
    chk("a_rst_data", a_data_o, 0);
    chk("a_rst_tag", a_tag_o, 0);
    chk("a_rst_occ", a_occ, 0);
    chk("a_rst_in_ready", a_in_ready, 1);
    chk("a_rst_busy", a_busy, 0);
    chk("b_rst_out_valid", b_out_valid, 0);
    chk("b_rst_occ", b_occ, 0);
    chk("b_rst_in_ready", b_in_ready, 1);
    @(posedge clk);
    #1;

    // Back-to-back tags 1..5, unstalled: latency 3, one per cycle, occupancy peak 3
    a_out_ready = 1'b1;
    a_occ_max   = 0;
    for (int t = 1; t <= 5; t++) push_a(8'(t), 1'b1);
    a_in_valid = 1'b0;
    drain_a();
    chk("a_occ_peak", a_occ_max, 3);
    chk("a_seen_5", a_seen, 5);

    // Stalled output: bubbles collapse, then ready drops at occupancy 3
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_tag_i = 8'h07; a_data_i = data_of(8'h07);
    @(negedge clk); chk("a_rdy_empty", a_in_ready, 1);
    @(posedge clk); #1; qa.push_back('{8'h07, data_of(8'h07), -1});
    a_tag_i = 8'h08; a_data_i = data_of(8'h08);
    @(negedge clk); chk("a_rdy_collapse1", a_in_ready, 1);
    @(posedge clk); #1; qa.push_back('{8'h08, data_of(8'h08), -1});
    a_tag_i = 8'h09; a_data_i = data_of(8'h09);
    @(negedge clk); chk("a_rdy_collapse2", a_in_ready, 1);
    @(posedge clk); #1; qa.push_back('{8'h09, data_of(8'h09), -1});
    a_tag_i = 8'h0A; a_data_i = data_of(8'h0A);
    @(negedge clk);
    chk("a_rdy_full", a_in_ready, 0);
    chk("a_occ_full", a_occ, 3);
    chk("a_head_tag", a_tag_o, 8'h07);
    chk("a_busy_full", a_busy, 1);
    @(posedge clk); #1;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    drain_a();

    // Selective kill: 0x12, 0x22 match tag 0x02 under mask 0x0F, 0x13 survives
    a_out_ready = 1'b0;
    push_a(8'h12, 1'b0);
    push_a(8'h22, 1'b0);
    push_a(8'h13, 1'b0);
    a_in_valid  = 1'b0;
    a_kill      = 1'b1;
    a_kill_tag  = 8'h02;
    a_kill_mask = 8'h0F;
    @(posedge clk); #1;
    a_kill = 1'b0;
    qa.delete();
    qa.push_back('{8'h13, data_of(8'h13), -1});
    @(negedge clk);
    chk("a_kill_occ", a_occ, 1);
    chk("a_kill_out_valid", a_out_valid, 0);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    drain_a();

    // Flush with kill and a same-cycle input: everything gone, 0x40 never delivered
    a_out_ready = 1'b0;
    push_a(8'h31, 1'b0);
    push_a(8'h32, 1'b0);
    a_tag_i = 8'h40; a_data_i = data_of(8'h40); a_in_valid = 1'b1;
    a_flush = 1'b1; a_kill = 1'b1; a_kill_tag = 8'h31; a_kill_mask = 8'hFF;
    @(posedge clk); #1;
    a_flush = 1'b0; a_kill = 1'b0; a_in_valid = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("a_flush_occ", a_occ, 0);
    chk("a_flush_out_valid", a_out_valid, 0);
    chk("a_flush_busy", a_busy, 0);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Reset with two stored entries and a stalled output
    a_out_ready = 1'b0;
    push_a(8'h51, 1'b0);
    push_a(8'h52, 1'b0);
    a_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("a_rst2_out_valid", a_out_valid, 0);
    chk("a_rst2_data", a_data_o, 0);
    chk("a_rst2_tag", a_tag_o, 0);
    chk("a_rst2_occ", a_occ, 0);
    chk("a_rst2_in_ready", a_in_ready, 1);
    @(posedge clk); #1;

    // Skid pipeline: 200 items under random backpressure
    b_occ_max = 0;
    b_rand    = 1'b1;
    for (int k = 0; k < 200; k++) push_b(8'(k), 1'b0);
    b_in_valid = 1'b0;
    drain_b();
    b_rand = 1'b0;
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    chk("b_count", b_seen, 200);
    chk("b_occ_le4", b_occ_max <= 4, 1);
    chk("b_ready_comb", b_comb_err, 0);

    // Skid pipeline unstalled latency: 2 cycles
    push_b(8'hC3, 1'b1);
    b_in_valid = 1'b0;
    drain_b();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
